// File: rtl/key_evt_pkg.sv
// Shared types and width helpers for the key event arbiter.
package key_evt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        GAP   = 2'd2
    } evt_state_t;

    // Width of the idle-gap counter when GAP_CYCLES is left at its default of 0.
    localparam int GAP_CNT_W_DEFAULT = 1;

    function automatic int key_idx_width(input int keys);
        return (keys <= 2) ? 1 : $clog2(keys);
    endfunction

    // Gap counter width: $clog2(gap+1), never below one bit.
    function automatic int gap_cnt_width(input int gap);
        int w;
        w = $clog2(gap + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_event_arbiter_rr_arbiter.sv
// Combinational round-robin select: first requester after the last grant, with wraparound.
module rr_arbiter
    import key_evt_pkg::*;
#(
    parameter int N = 4,
    parameter int W = key_idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant,
    output logic         any_req
);

    logic         found;
    logic [W-1:0] sel;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = '0;
        // Offsets 1..N visit every index once; offset N is the last grant itself.
        for (int i = 1; i <= N; i++) begin
            sel = W'((int'(last) + i) % N);
            if (!found && req[sel]) begin
                grant = sel;
                found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/key_event_arbiter.sv
// Queues one pending press per key and hands them to a single consumer, round-robin, with an optional idle gap.
module key_event_arbiter
    import key_evt_pkg::*;
#(
    parameter int KEYS_CNT   = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [KEYS_CNT-1:0]                 key_stb_i,
    output logic                                evt_valid_o,
    output logic [key_idx_width(KEYS_CNT)-1:0]  evt_key_o,
    input  logic                                evt_ready_i,
    output logic [KEYS_CNT-1:0]                 overrun_o,
    input  logic                                clr_overrun_i
);

    localparam int KEY_W = key_idx_width(KEYS_CNT);
    localparam int GAP_W = gap_cnt_width(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    // Handshake: an event transfers in any cycle where evt_valid_o and evt_ready_i are
    // both high; once raised, evt_valid_o and evt_key_o hold until that transfer.
    evt_state_t           state;
    logic [KEYS_CNT-1:0]  pending;
    logic [KEY_W-1:0]     last_q;
    logic [GAP_W-1:0]     gap_cnt;
    logic [KEY_W-1:0]     grant;
    logic                 any_req;
    logic                 accept;
    logic [KEYS_CNT-1:0]  accept_mask;
    logic [KEYS_CNT-1:0]  new_ovr;

    rr_arbiter #(
        .N (KEYS_CNT),
        .W (KEY_W)
    ) u_rr (
        .req     (pending),
        .last    (last_q),
        .grant   (grant),
        .any_req (any_req)
    );

    assign accept      = evt_valid_o & evt_ready_i;
    assign accept_mask = accept ? (KEYS_CNT'(1) << evt_key_o) : '0;
    // A strobe on a key whose event is being taken this cycle re-arms it instead of overrunning.
    assign new_ovr     = key_stb_i & pending & ~accept_mask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending   <= '0;
            overrun_o <= '0;
        end else begin
            pending   <= (pending & ~accept_mask) | key_stb_i;
            overrun_o <= (clr_overrun_i ? '0 : overrun_o) | new_ovr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            evt_valid_o <= 1'b0;
            evt_key_o   <= '0;
            last_q      <= KEY_W'(KEYS_CNT - 1);
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        evt_key_o   <= grant;
                        evt_valid_o <= 1'b1;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (evt_ready_i) begin
                        evt_valid_o <= 1'b0;
                        last_q      <= evt_key_o;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: one instance with no gap, one with a five-cycle gap.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] stb0, stb5;
    logic       ready0, ready5;
    logic       valid0, valid5;
    logic [1:0] key0, key5;
    logic [3:0] ovr0, ovr5;
    logic       clr0, clr5;

    logic [1:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    key_event_arbiter #(.KEYS_CNT(4), .GAP_CYCLES(0)) dut0 (
        .clk_i         (clk),
        .rst_i         (rst),
        .key_stb_i     (stb0),
        .evt_valid_o   (valid0),
        .evt_key_o     (key0),
        .evt_ready_i   (ready0),
        .overrun_o     (ovr0),
        .clr_overrun_i (clr0)
    );

    key_event_arbiter #(.KEYS_CNT(4), .GAP_CYCLES(5)) dut5 (
        .clk_i         (clk),
        .rst_i         (rst),
        .key_stb_i     (stb5),
        .evt_valid_o   (valid5),
        .evt_key_o     (key5),
        .evt_ready_i   (ready5),
        .overrun_o     (ovr5),
        .clr_overrun_i (clr5)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst  = 1'b1;
        stb0 = '0;
        stb5 = '0;
        clr0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: every accepted event on dut0 must match the oldest expected key.
    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (!rst && valid0 && ready0) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_event", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_key", 32'(key0), 32'(e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst    = 1'b1;
        stb0   = '0;
        stb5   = '0;
        ready0 = 1'b0;
        ready5 = 1'b1;
        clr0   = 1'b0;
        clr5   = 1'b0;
        tick();
        samp();
        check_eq("rst_valid", 32'(valid0), 32'd0);
        check_eq("rst_key", 32'(key0), 32'd0);
        check_eq("rst_overrun", 32'(ovr0), 32'd0);
        check_eq("rst_valid_gap", 32'(valid5), 32'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();

        // Single strobe on key 2: valid two cycles later, gone the cycle after acceptance.
        ready0 = 1'b1;
        stb0   = 4'b0100;
        exp_q.push_back(2'd2);
        tick();
        stb0 = '0;
        samp();
        check_eq("t1_valid_n1", 32'(valid0), 32'd0);
        tick();
        samp();
        check_eq("t1_valid_n2", 32'(valid0), 32'd1);
        check_eq("t1_key_n2", 32'(key0), 32'd2);
        tick();
        samp();
        check_eq("t1_valid_n3", 32'(valid0), 32'd0);
        tick();

        // All four keys at once: 0,1,2,3 every other cycle.
        do_reset();
        ready0 = 1'b1;
        stb0   = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
        for (int c = 0; c < 11; c++) begin
            samp();
            check_eq($sformatf("t2_valid_c%0d", c), 32'(valid0),
                     32'((c >= 2 && c <= 8 && (c % 2) == 0) ? 1 : 0));
            tick();
            stb0 = '0;
        end
        check_eq("t2_no_overrun", 32'(ovr0), 32'd0);

        // Fairness: key 1 hammered every 3 cycles, key 3 once.
        do_reset();
        ready0 = 1'b1;
        for (int c = 0; c < 15; c++) begin
            stb0 = '0;
            if ((c % 3) == 0 && c <= 9) begin
                stb0[1] = 1'b1;
                exp_q.push_back(2'd1);
            end
            if (c == 1) begin
                stb0[3] = 1'b1;
                exp_q.push_back(2'd3);
            end
            samp();
            if (c == 4) begin
                check_eq("t3_key3_valid", 32'(valid0), 32'd1);
                check_eq("t3_key3_key", 32'(key0), 32'd3);
            end
            tick();
        end
        stb0 = '0;
        check_eq("t3_no_overrun", 32'(ovr0), 32'd0);

        // Back-pressure, overrun, clear priority, strobe in the accept cycle.
        do_reset();
        ready0 = 1'b0;
        for (int c = 0; c < 29; c++) begin
            stb0 = '0;
            clr0 = 1'b0;
            if (c == 0) begin
                stb0[0] = 1'b1;
                exp_q.push_back(2'd0);
            end
            if (c == 5) stb0[0] = 1'b1;
            if (c == 7) begin
                stb0[1] = 1'b1;
                exp_q.push_back(2'd1);
            end
            if (c == 8) stb0[1] = 1'b1;
            if (c == 10) begin
                stb0[0] = 1'b1;
                clr0    = 1'b1;
            end
            if (c == 12) clr0 = 1'b1;
            if (c == 22) begin
                ready0  = 1'b1;
                stb0[0] = 1'b1;
                exp_q.push_back(2'd0);
            end
            samp();
            if (c >= 2 && c <= 22) begin
                check_eq($sformatf("t4_stall_valid_c%0d", c), 32'(valid0), 32'd1);
                check_eq($sformatf("t4_stall_key_c%0d", c), 32'(key0), 32'd0);
            end
            if (c == 6)  check_eq("t4_ovr_key0", 32'(ovr0), 32'h1);
            if (c == 9)  check_eq("t4_ovr_key1", 32'(ovr0), 32'h3);
            if (c == 11) check_eq("t4_clr_vs_new", 32'(ovr0), 32'h1);
            if (c == 13) check_eq("t4_clr", 32'(ovr0), 32'h0);
            if (c == 23) check_eq("t4_valid_after_accept", 32'(valid0), 32'd0);
            if (c == 24) begin
                check_eq("t4_next_valid", 32'(valid0), 32'd1);
                check_eq("t4_next_key", 32'(key0), 32'd1);
            end
            if (c == 26) begin
                check_eq("t4_represent_valid", 32'(valid0), 32'd1);
                check_eq("t4_represent_key", 32'(key0), 32'd0);
            end
            if (c == 27) check_eq("t4_no_new_overrun", 32'(ovr0), 32'h0);
            tick();
        end
        stb0 = '0;
        clr0 = 1'b0;

        // Five-cycle gap: accept in cycle 2, next valid in cycle 9.
        do_reset();
        ready5 = 1'b1;
        stb5   = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            samp();
            check_eq($sformatf("t5_valid_c%0d", c), 32'(valid5),
                     32'((c == 2 || c == 9) ? 1 : 0));
            if (c == 2) check_eq("t5_first_key", 32'(key5), 32'd0);
            if (c == 9) check_eq("t5_second_key", 32'(key5), 32'd2);
            tick();
            stb5 = '0;
        end

        // Reset while presenting with three keys pending.
        do_reset();
        ready0 = 1'b0;
        stb0   = 4'b1110;
        tick();
        stb0 = '0;
        tick();
        samp();
        check_eq("t6_pre_valid", 32'(valid0), 32'd1);
        check_eq("t6_pre_key", 32'(key0), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("t6_async_valid", 32'(valid0), 32'd0);
        check_eq("t6_async_key", 32'(key0), 32'd0);
        tick();
        rst    = 1'b0;
        ready0 = 1'b1;
        stb0   = 4'b0101;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        tick();
        stb0 = '0;
        for (int c = 1; c < 11; c++) begin
            samp();
            if (c == 2) begin
                check_eq("t6_first_valid", 32'(valid0), 32'd1);
                check_eq("t6_first_key", 32'(key0), 32'd0);
            end
            if (c == 4) begin
                check_eq("t6_second_valid", 32'(valid0), 32'd1);
                check_eq("t6_second_key", 32'(key0), 32'd2);
            end
            tick();
        end
        samp();
        check_eq("t6_idle_after", 32'(valid0), 32'd0);
        check_eq("final_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
